// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : ctrl_pkg                                                       |
// | Shared definitions for the LEGv8 control units: FSM states, instruction  |
// | classes, ALU function codes, opcode patterns and fault codes.            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5,
    CLS_MOVZ    = 3'd6
  } iclass_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  // Fully specified opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Opcodes with don't-care low bits, matched as (op & MASK) == VAL
  localparam logic [10:0] OP_CBZ_VAL   = 11'b10110100000;
  localparam logic [10:0] OP_CBZ_MASK  = 11'b11111111000;
  localparam logic [10:0] OP_B_VAL     = 11'b00010100000;
  localparam logic [10:0] OP_B_MASK    = 11'b11111100000;
  localparam logic [10:0] OP_MOVZ_VAL  = 11'b11010010100;
  localparam logic [10:0] OP_MOVZ_MASK = 11'b11111111100;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_HOLD   = 2'd2;

  localparam logic [1:0] ALU_SRC_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC_MOVZ = 2'd2;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_opdecode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ctrl_opdecode                                                  |
// | Combinational opcode decoder: 11-bit opcode -> instruction class and ALU |
// | function. Shared between the single-cycle and multicycle controls.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output iclass_e     iclass,
  output logic [3:0]  alu_op
);

  // Classify the opcode; address calculation uses ADD, CBZ/MOVZ pass operand B
  always_comb begin
    iclass = CLS_ILLEGAL;
    alu_op = ALU_AND;
    if (opcode == OP_ADD) begin
      iclass = CLS_RTYPE;
      alu_op = ALU_ADD;
    end else if (opcode == OP_SUB) begin
      iclass = CLS_RTYPE;
      alu_op = ALU_SUB;
    end else if (opcode == OP_AND) begin
      iclass = CLS_RTYPE;
      alu_op = ALU_AND;
    end else if (opcode == OP_ORR) begin
      iclass = CLS_RTYPE;
      alu_op = ALU_ORR;
    end else if (opcode == OP_LDUR) begin
      iclass = CLS_LOAD;
      alu_op = ALU_ADD;
    end else if (opcode == OP_STUR) begin
      iclass = CLS_STORE;
      alu_op = ALU_ADD;
    end else if (op_match(opcode, OP_CBZ_VAL, OP_CBZ_MASK)) begin
      iclass = CLS_CBZ;
      alu_op = ALU_PASSB;
    end else if (op_match(opcode, OP_B_VAL, OP_B_MASK)) begin
      iclass = CLS_B;
      alu_op = ALU_AND;
    end else if (op_match(opcode, OP_MOVZ_VAL, OP_MOVZ_MASK)) begin
      iclass = CLS_MOVZ;
      alu_op = ALU_PASSB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : multicycle_ctrl                                                |
// | Control FSM for the LEGv8 multicycle datapath. Sequences FETCH/DECODE/   |
// | EXEC/MEM/WB, drives datapath enables and muxes, handshakes with the      |
// | memories, flags illegal opcodes / memory timeouts, counts retirements.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [10:0]      opcode,
  input  logic             alu_zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg2loc,
  output logic [1:0]       alu_src,
  output logic [3:0]       alu_op,
  output logic [1:0]       movz_hw,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instr_count
);

  // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1
  localparam int            TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       fault_q, fault_d;
  logic             halt_pend_q, halt_pend_d;

  iclass_e          iclass;
  logic [3:0]       dec_alu_op;
  logic             uses_rt;
  logic             retire;
  logic             wait_expired;

  ctrl_opdecode u_opdecode (
    .opcode (opcode),
    .iclass (iclass),
    .alu_op (dec_alu_op)
  );

  assign uses_rt = (iclass == CLS_STORE) || (iclass == CLS_CBZ);

  // State register and bookkeeping flops; reset aborts any outstanding request
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      count_q     <= '0;
      fault_q     <= FAULT_NONE;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state logic: sequencing, timeouts, retirement and halt at boundaries
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    count_d      = count_q;
    fault_d      = fault_q;
    halt_pend_d  = halt_pend_q;
    retire       = 1'b0;
    wait_expired = (wait_q == WAIT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          wait_d      = '0;
          // start wins over a simultaneous halt; remember it for the first boundary
          halt_pend_d = halt_req;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      ST_DECODE: begin
        if (iclass == CLS_ILLEGAL) begin
          state_d = ST_HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (iclass)
          CLS_CBZ, CLS_B: retire = 1'b1;
          CLS_LOAD, CLS_STORE: begin
            state_d = ST_MEM;
            wait_d  = '0;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (iclass == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire = 1'b1;
          end
        end else if (wait_expired) begin
          state_d = ST_HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      ST_WB: retire = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Instruction boundary: count it, then either fetch the next one or stop
    if (retire) begin
      count_d = count_q + CNT_W'(1);
      if (halt_req || halt_pend_q) begin
        state_d     = ST_HALT;
        halt_pend_d = 1'b0;
      end else begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
    end
  end

  // Output decode from registered state and current opcode class
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_HOLD;
    reg2loc    = 1'b0;
    alu_src    = ALU_SRC_REG;
    alu_op     = ALU_AND;
    movz_hw    = 2'd0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted     = (state_q == ST_HALT);

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
        pc_write = imem_ack;
        pc_src   = PC_SRC_SEQ;
      end
      ST_DECODE: reg2loc = uses_rt;
      ST_EXEC: begin
        reg2loc = uses_rt;
        alu_op  = dec_alu_op;
        case (iclass)
          CLS_LOAD, CLS_STORE: alu_src = ALU_SRC_IMM;
          CLS_MOVZ: begin
            alu_src = ALU_SRC_MOVZ;
            movz_hw = opcode[1:0];
          end
          CLS_B: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_BRANCH;
          end
          CLS_CBZ: begin
            pc_write = alu_zero;
            pc_src   = PC_SRC_BRANCH;
          end
          default: alu_src = ALU_SRC_REG;
        endcase
      end
      ST_MEM: begin
        reg2loc    = uses_rt;
        dmem_read  = (iclass == CLS_LOAD);
        dmem_write = (iclass == CLS_STORE);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (iclass == CLS_LOAD);
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_multicycle_ctrl                                             |
// | Self-checking bench for multicycle_ctrl: phase-level reference model,   |
// | per-cycle output comparison, plus literal spot checks.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  localparam logic [10:0] I_ADD  = 11'b10001011000;
  localparam logic [10:0] I_SUB  = 11'b11001011000;
  localparam logic [10:0] I_AND  = 11'b10001010000;
  localparam logic [10:0] I_ORR  = 11'b10101010000;
  localparam logic [10:0] I_LDUR = 11'b11111000010;
  localparam logic [10:0] I_STUR = 11'b11111000000;
  localparam logic [10:0] I_CBZ  = 11'b10110100101;
  localparam logic [10:0] I_B    = 11'b00010111011;
  localparam logic [10:0] I_MOVZ = 11'b11010010110;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3,
                 PH_MEM = 4, PH_WB = 5, PH_HALT = 6;
  localparam int C_ILL = 0, C_R = 1, C_LD = 2, C_ST = 3, C_CBZ = 4, C_B = 5, C_MOVZ = 6;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic [10:0] opcode = '0;
  logic        alu_zero = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;

  logic             imem_req, ir_write, pc_write, reg2loc;
  logic [1:0]       pc_src, alu_src, movz_hw, fault;
  logic [3:0]       alu_op;
  logic             dmem_read, dmem_write, mem_to_reg, reg_write, busy, halted;
  logic [CNT_W-1:0] instr_count;

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .halt_req(halt_req), .opcode(opcode),
    .alu_zero(alu_zero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op), .movz_hw(movz_hw),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .busy(busy), .halted(halted), .fault(fault),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg2loc;
    logic [1:0]       alu_src;
    logic [3:0]       alu_op;
    logic [1:0]       movz_hw;
    logic             dmem_read;
    logic             dmem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             busy;
    logic             halted;
    logic [1:0]       fault;
    logic [CNT_W-1:0] instr_count;
  } obs_t;

  obs_t exp_q[$];
  obs_t seen[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference-model state
  int         m_count = 0;
  logic [1:0] m_fault = 2'd0;

  function automatic int cls_of(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: return C_R;
      11'b11111000010: return C_LD;
      11'b11111000000: return C_ST;
      11'b10110100???: return C_CBZ;
      11'b000101?????: return C_B;
      11'b110100101??: return C_MOVZ;
      default:         return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] aluop_of(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11111000010, 11'b11111000000: return 4'b0010;
      11'b11001011000: return 4'b0110;
      11'b10101010000: return 4'b0001;
      11'b10110100???, 11'b110100101??: return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  // Expected outputs for one cycle spent in a given phase of an instruction
  function automatic obs_t model(input int ph, input logic [10:0] op,
                                 input logic ia, input logic z);
    obs_t e;
    int   c;
    c = cls_of(op);
    e = '0;
    e.pc_src      = 2'd2;
    e.fault       = m_fault;
    e.instr_count = CNT_W'(m_count);
    e.busy        = (ph != PH_IDLE) && (ph != PH_HALT);
    e.halted      = (ph == PH_HALT);
    case (ph)
      PH_FETCH: begin
        e.imem_req = 1'b1;
        e.ir_write = ia;
        e.pc_write = ia;
        e.pc_src   = 2'd0;
      end
      PH_DECODE: e.reg2loc = (c == C_ST) || (c == C_CBZ);
      PH_EXEC: begin
        e.reg2loc = (c == C_ST) || (c == C_CBZ);
        e.alu_op  = aluop_of(op);
        e.alu_src = (c == C_LD || c == C_ST) ? 2'd1 : (c == C_MOVZ) ? 2'd2 : 2'd0;
        e.movz_hw = (c == C_MOVZ) ? op[1:0] : 2'd0;
        if (c == C_B) begin
          e.pc_write = 1'b1;
          e.pc_src   = 2'd1;
        end else if (c == C_CBZ) begin
          e.pc_write = z;
          e.pc_src   = 2'd1;
        end
      end
      PH_MEM: begin
        e.reg2loc    = (c == C_ST);
        e.dmem_read  = (c == C_LD);
        e.dmem_write = (c == C_ST);
      end
      PH_WB: begin
        e.reg_write  = 1'b1;
        e.mem_to_reg = (c == C_LD);
      end
      default: e.pc_src = 2'd2;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.imem_req = imem_req;     o.ir_write = ir_write;     o.pc_write = pc_write;
    o.pc_src = pc_src;         o.reg2loc = reg2loc;       o.alu_src = alu_src;
    o.alu_op = alu_op;         o.movz_hw = movz_hw;       o.dmem_read = dmem_read;
    o.dmem_write = dmem_write; o.mem_to_reg = mem_to_reg; o.reg_write = reg_write;
    o.busy = busy;             o.halted = halted;         o.fault = fault;
    o.instr_count = instr_count;
    return o;
  endfunction

  // Compare process: every cycle with a pending expectation is checked mid-cycle
  always @(negedge CLK) begin
    obs_t act;
    obs_t e;
    act = sample();
    seen.push_back(act);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL cycle%0d outputs: act=%h exp=%h", seen.size() - 1, act, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int ph);
    exp_q.push_back(model(ph, opcode, imem_ack, alu_zero));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt_req = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0;
    @(posedge CLK);
    #1;
    reset   = 1'b0;
    m_count = 0;
    m_fault = 2'd0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick(PH_IDLE);
    start = 1'b0;
  endtask

  // One full instruction from FETCH through retirement (or illegal-opcode halt)
  task automatic run_instr(input logic [10:0] op, input int iwait, input int dwait,
                           input logic z, input logic halt_after);
    int c;
    c = cls_of(op);
    imem_ack = 1'b0;
    for (int i = 0; i < iwait; i++) tick(PH_FETCH);
    imem_ack = 1'b1;
    tick(PH_FETCH);
    imem_ack = 1'b0;
    opcode = op;
    tick(PH_DECODE);
    if (c == C_ILL) begin
      m_fault = 2'd1;
    end else begin
      alu_zero = z;
      if (c == C_B || c == C_CBZ) begin
        halt_req = halt_after;
        tick(PH_EXEC);
        m_count++;
      end else begin
        tick(PH_EXEC);
        if (c == C_LD || c == C_ST) begin
          for (int i = 0; i < dwait; i++) tick(PH_MEM);
          dmem_ack = 1'b1;
          if (c == C_ST) halt_req = halt_after;
          tick(PH_MEM);
          dmem_ack = 1'b0;
          if (c == C_ST) m_count++;
        end
        if (c != C_ST) begin
          halt_req = halt_after;
          tick(PH_WB);
          m_count++;
        end
      end
    end
    halt_req = 1'b0;
    alu_zero = 1'b0;
  endtask

  initial begin
    int mark;
    int n;
    obs_t s;

    // Reset state
    do_reset();
    tick(PH_IDLE);
    s = seen[seen.size() - 1];
    chk("reset_pc_src", 32'(s.pc_src), 32'd2);
    chk("reset_count", s.instr_count, 32'd0);

    // ADD with zero-wait memory: FETCH, DECODE, EXEC, WB
    start_pulse();
    mark = seen.size();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
    chk("add_cycles", 32'(seen.size() - mark), 32'd4);
    chk("add_alu_op", 32'(seen[mark + 2].alu_op), 32'b0010);
    chk("add_reg_write_c4", 32'(seen[mark + 3].reg_write), 32'd1);
    chk("add_count", instr_count, 32'd1);

    // Remaining ALU ops, branch and store back-to-back
    run_instr(I_SUB, 0, 0, 1'b0, 1'b0);
    run_instr(I_AND, 1, 0, 1'b0, 1'b0);
    run_instr(I_ORR, 0, 0, 1'b0, 1'b0);
    mark = seen.size();
    run_instr(I_B, 0, 0, 1'b0, 1'b0);
    chk("b_cycles", 32'(seen.size() - mark), 32'd3);
    run_instr(I_STUR, 0, 0, 1'b0, 1'b0);

    // LDUR with data ack delayed 3 cycles
    mark = seen.size();
    run_instr(I_LDUR, 0, 3, 1'b0, 1'b0);
    n = 0;
    for (int i = mark; i < seen.size(); i++) if (seen[i].dmem_read) n++;
    chk("ldur_cycles", 32'(seen.size() - mark), 32'd8);
    chk("ldur_dmem_read_cycles", 32'(n), 32'd4);
    chk("ldur_wb_mem_to_reg", 32'(seen[mark + 7].mem_to_reg), 32'd1);
    chk("ldur_wb_reg_write", 32'(seen[mark + 7].reg_write), 32'd1);

    // CBZ not taken / taken
    mark = seen.size();
    run_instr(I_CBZ, 0, 0, 1'b0, 1'b0);
    chk("cbz_nz_pc_write", 32'(seen[mark + 2].pc_write), 32'd0);
    mark = seen.size();
    run_instr(I_CBZ, 0, 0, 1'b1, 1'b0);
    chk("cbz_z_pc_write", 32'(seen[mark + 2].pc_write), 32'd1);
    chk("cbz_z_pc_src", 32'(seen[mark + 2].pc_src), 32'd1);

    // MOVZ hw=2
    mark = seen.size();
    run_instr(I_MOVZ, 0, 0, 1'b0, 1'b0);
    chk("movz_alu_src", 32'(seen[mark + 2].alu_src), 32'd2);
    chk("movz_hw", 32'(seen[mark + 2].movz_hw), 32'd2);
    chk("movz_alu_op", 32'(seen[mark + 2].alu_op), 32'b0111);

    // Acks arriving on the final allowed wait cycle still succeed
    mark = seen.size();
    run_instr(I_STUR, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, 1'b0);
    chk("edge_ack_cycles", 32'(seen.size() - mark), 32'(2 * MEM_TIMEOUT + 2));
    chk("edge_ack_count", instr_count, 32'd11);

    // Reset asserted mid-MEM of a load
    imem_ack = 1'b1;
    tick(PH_FETCH);
    imem_ack = 1'b0;
    opcode = I_LDUR;
    tick(PH_DECODE);
    tick(PH_EXEC);
    tick(PH_MEM);
    reset = 1'b1;
    tick(PH_MEM);
    reset   = 1'b0;
    m_count = 0;
    m_fault = 2'd0;
    tick(PH_IDLE);
    chk("midmem_read_before", 32'(seen[seen.size() - 2].dmem_read), 32'd1);
    s = seen[seen.size() - 1];
    chk("midmem_read_after", 32'(s.dmem_read), 32'd0);
    chk("midmem_count", s.instr_count, 32'd0);
    chk("midmem_busy", 32'(s.busy), 32'd0);

    // Illegal opcode halts without retiring; start ignored in HALT
    start_pulse();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0);
    run_instr(11'd0, 0, 0, 1'b0, 1'b0);
    tick(PH_HALT);
    start = 1'b1;
    tick(PH_HALT);
    start = 1'b0;
    tick(PH_HALT);
    s = seen[seen.size() - 1];
    chk("illegal_halted", 32'(s.halted), 32'd1);
    chk("illegal_fault", 32'(s.fault), 32'd1);
    chk("illegal_count", s.instr_count, 32'd1);

    // Instruction fetch never acknowledged
    do_reset();
    start_pulse();
    mark = seen.size();
    for (int i = 0; i < MEM_TIMEOUT; i++) tick(PH_FETCH);
    m_fault = 2'd2;
    tick(PH_HALT);
    n = 0;
    for (int i = mark; i < seen.size(); i++) if (seen[i].imem_req) n++;
    chk("timeout_req_cycles", 32'(n), 32'd16);
    chk("timeout_fault", 32'(seen[seen.size() - 1].fault), 32'd2);

    // halt_req during WB: retire then HALT; start ignored afterwards
    do_reset();
    start_pulse();
    run_instr(I_ADD, 0, 0, 1'b0, 1'b1);
    tick(PH_HALT);
    start = 1'b1;
    tick(PH_HALT);
    start = 1'b0;
    tick(PH_HALT);
    s = seen[seen.size() - 1];
    chk("haltwb_count", s.instr_count, 32'd1);
    chk("haltwb_fault", 32'(s.fault), 32'd0);

    // start together with halt_req in IDLE: one instruction, then HALT
    do_reset();
    start = 1'b1;
    halt_req = 1'b1;
    tick(PH_IDLE);
    start = 1'b0;
    halt_req = 1'b0;
    run_instr(I_B, 0, 0, 1'b0, 1'b0);
    tick(PH_HALT);
    s = seen[seen.size() - 1];
    chk("starthalt_halted", 32'(s.halted), 32'd1);
    chk("starthalt_count", s.instr_count, 32'd1);

    @(posedge CLK);
    #1;
    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
